// File: rtl/dft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dft_pkg                                                      |
// | Description : Shared types and helpers for the DFT twiddle multiplier:     |
// |               complex Q1.15 sample type, Q1.15 limits, FSM state encoding  |
// |               and a 33-bit to 16-bit signed saturator.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package dft_pkg;

  // Complex Q1.15 value; re occupies the upper half of the packed word.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  localparam logic [15:0]        Q15_ONE = 16'h7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a 33-bit signed value into the Q1.15 range [-32768, 32767].
  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -33'sd32768) begin
      return Q15_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dft_twiddle_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dft_twiddle_rom                                              |
// | Description : Synchronous twiddle ROM. Entry p holds                       |
// |               {cos(2*pi*p/N), -sin(2*pi*p/N)} in Q1.15, rounded to nearest |
// |               and clamped to [-32767, 32767].                              |
// | Ports       : clk  - rising-edge clock                                     |
// |               addr - phase index [LOG2N-1:0]                               |
// |               data - registered twiddle (cplx_t), valid the cycle after    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dft_twiddle_rom
  import dft_pkg::*;
#(
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic [LOG2N-1:0] addr,
  output cplx_t            data
);

  // pi scaled by 2^30; all table arithmetic is 64-bit fixed point at 2^30.
  localparam longint PI_FX = 64'sd3373259426;

  function automatic logic signed [15:0] to_q15(input longint v);
    longint r;
    longint lim;
    lim = longint'(Q15_ONE);
    r   = (v + (64'sd1 <<< 14)) >>> 15;
    if (r > lim) begin
      r = lim;
    end else if (r < -lim) begin
      r = -lim;
    end
    return r[15:0];
  endfunction

  // Taylor series over the first quadrant, then quadrant symmetry. Ten terms
  // keep the error far below one Q1.15 LSB for angles under pi/2.
  function automatic cplx_t tw_entry(input int p);
    longint theta;
    longint x2;
    longint term;
    longint s_fx;
    longint c_fx;
    longint cos_fx;
    longint sin_fx;
    int     quarter;
    int     q;
    int     quad;
    cplx_t  e;
    quarter = N / 4;
    q       = p % quarter;
    quad    = p / quarter;
    theta   = (64'sd2 * PI_FX * longint'(q)) / longint'(N);
    x2      = (theta * theta) >>> 30;
    s_fx    = 64'sd0;
    term    = theta;
    for (int i = 1; i <= 10; i++) begin
      s_fx = s_fx + term;
      term = -(((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
    end
    c_fx = 64'sd0;
    term = 64'sd1 <<< 30;
    for (int i = 1; i <= 10; i++) begin
      c_fx = c_fx + term;
      term = -(((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i)));
    end
    case (quad)
      0:       begin cos_fx =  c_fx; sin_fx =  s_fx; end
      1:       begin cos_fx = -s_fx; sin_fx =  c_fx; end
      2:       begin cos_fx = -c_fx; sin_fx = -s_fx; end
      default: begin cos_fx =  s_fx; sin_fx = -c_fx; end
    endcase
    e.re = to_q15(cos_fx);
    e.im = to_q15(-sin_fx);
    return e;
  endfunction

  cplx_t w_table [N];

  for (genvar p = 0; p < N; p++) begin : g_rom
    localparam cplx_t ENTRY = tw_entry(p);
    assign w_table[p] = ENTRY;
  end

  always_ff @(posedge clk) begin
    data <= w_table[addr];
  end

endmodule
`default_nettype wire

// File: rtl/dft_twiddle_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dft_twiddle_mult                                             |
// | Description : Multiplies each sample of a frame by W_N^(k*n) for one bin k |
// |               and streams rounded, saturated products to a downstream     |
// |               accumulator. A zero word at frame start clears it.           |
// | Ports       : clk, nrst (sync, active-low)                                 |
// |               start, bin_k            - frame launch and bin index         |
// |               in_valid/in_data/in_ready - sample stream, {re,im} Q1.15     |
// |               out_data/out_ce/out_last  - product stream                   |
// |               busy, done              - frame status                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dft_twiddle_mult
  import dft_pkg::*;
#(
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [LOG2N-1:0] bin_k,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_ce,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [LOG2N-1:0] r_k;
  logic [LOG2N-1:0] r_phase;
  logic [LOG2N-1:0] r_cnt;
  logic             w_start_ok;
  logic             w_accept;

  // Pipeline: S1 sample + ROM word, S2 partial products, then output register.
  logic               r_s1_valid;
  logic               r_s1_last;
  cplx_t              r_s1_x;
  cplx_t              w_tw;
  logic               r_s2_valid;
  logic               r_s2_last;
  logic signed [31:0] r_ac;
  logic signed [31:0] r_bd;
  logic signed [31:0] r_ad;
  logic signed [31:0] r_bc;

  logic signed [32:0] w_re_sum;
  logic signed [32:0] w_im_sum;
  logic signed [32:0] w_re_rnd;
  logic signed [32:0] w_im_rnd;
  logic [31:0]        w_prod;
  logic [31:0]        w_result;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == LAST_CNT)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // out_last marks the final product leaving the pipeline.
        if (out_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  dft_twiddle_rom #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_rom (
    .clk  (clk),
    .addr (r_phase),
    .data (w_tw)
  );

  // Control and valid bits: all cleared by reset so in-flight products vanish.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_phase    <= '0;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      out_ce     <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_k     <= bin_k;
        r_phase <= '0;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_phase <= r_phase + r_k;
        r_cnt   <= r_cnt + 1'b1;
      end
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && (r_cnt == LAST_CNT);
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      out_ce     <= r_s2_valid;
      out_last   <= r_s2_valid && r_s2_last;
      // Zero word clears the accumulator; otherwise hold between products.
      if (w_start_ok) begin
        out_data <= '0;
      end else if (r_s2_valid) begin
        out_data <= w_result;
      end
      done <= (r_state == DRAIN) && out_last;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    r_s1_x <= in_data;
    r_ac   <= r_s1_x.re * w_tw.re;
    r_bd   <= r_s1_x.im * w_tw.im;
    r_ad   <= r_s1_x.re * w_tw.im;
    r_bc   <= r_s1_x.im * w_tw.re;
  end

  assign w_re_sum = {r_ac[31], r_ac} - {r_bd[31], r_bd};
  assign w_im_sum = {r_ad[31], r_ad} + {r_bc[31], r_bc};
  assign w_re_rnd = (w_re_sum + 33'sd16384) >>> 15;
  assign w_im_rnd = (w_im_sum + 33'sd16384) >>> 15;
  assign w_prod   = {sat16(w_re_rnd), sat16(w_im_rnd)};

  // A zero product would read as a clear downstream; nudge im by one LSB.
  assign w_result = (w_prod == 32'd0) ? 32'd1 : w_prod;

endmodule
`default_nettype wire

// File: tb/tb_dft_twiddle_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dft_twiddle_mult                                          |
// | Description : Scoreboard bench for dft_twiddle_mult. The driver pushes the |
// |               expected product, last flag and arrival cycle for every      |
// |               accepted sample; a monitor pops and compares on out_ce.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dft_twiddle_mult;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  bin_k = 4'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_ce;
  logic        out_last;
  logic        busy;
  logic        done;

  dft_twiddle_mult #(.N(16), .LOG2N(4)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .bin_k    (bin_k),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ce   (out_ce),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   prod_cnt = 0;
  logic prev_last = 1'b0;
  int   m_k = 0;
  int   m_phase = 0;
  int   m_n = 0;

  // Monitor: products against the scoreboard, done exactly after out_last.
  always @(negedge clk) begin
    if (prev_last) begin
      tests++;
      if (done !== 1'b1) begin
        fails++;
        $display("FAIL done_pulse: done=%b required 1", done);
      end
    end else if (done === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL done_spurious: done=%b required 0", done);
    end
    prev_last <= (out_ce === 1'b1) && (out_last === 1'b1);
    if (out_ce === 1'b1) begin
      prod_cnt++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_ce: out_data=%h cycle=%0d required no product", out_data, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (out_data !== mon_e.data || out_last !== mon_e.last || cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL product: got data=%h last=%b cycle=%0d required data=%h last=%b cycle=%0d",
                   out_data, out_last, cyc, mon_e.data, mon_e.last, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic longint q15r(input real v);
    longint r;
    r = longint'($floor(v * 32768.0 + 0.5));
    if (r > 32767) r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  function automatic longint rnd_sat(input longint v);
    longint r;
    r = (v + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Reference product of sample x with twiddle at phase p.
  function automatic logic [31:0] model(input logic [31:0] x, input int p);
    real    ang;
    longint wr, wi, a, b, re, im;
    logic [15:0] re16, im16;
    ang  = 2.0 * 3.141592653589793 * real'(p) / 16.0;
    wr   = q15r($cos(ang));
    wi   = q15r(-$sin(ang));
    a    = longint'($signed(x[31:16]));
    b    = longint'($signed(x[15:0]));
    re   = rnd_sat(a * wr - b * wi);
    im   = rnd_sat(a * wi + b * wr);
    if (re == 0 && im == 0) return 32'h0000_0001;
    re16 = 16'(re);
    im16 = 16'(im);
    return {re16, im16};
  endfunction

  function automatic logic [31:0] samp(input int n);
    logic [15:0] a, b;
    a = 16'(n * 2100 - 16000);
    b = 16'(9000 - n * 1300);
    return {a, b};
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic start_frame(input int k);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("start_idle_wait", {31'd0, busy}, 32'd0);
    start = 1'b1;
    bin_k = 4'(k);
    @(negedge clk);
    start = 1'b0;
    bin_k = 4'hF;
    check("clear_word_data", out_data, 32'd0);
    check("clear_word_ce", {31'd0, out_ce}, 32'd0);
    m_k     = k;
    m_phase = 0;
    m_n     = 0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] expv, input int gap);
    int   t = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      e.data = expv;
      e.last = (m_n == N - 1);
      e.cyc  = cyc + 3;
      sbq.push_back(e);
      m_phase = (m_phase + m_k) % N;
      m_n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sbq.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_complete", {31'd0, (t < 200)}, 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] x;
  logic [31:0] ev;
  int          ce_seen;
  int          p0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out_data", out_data, 32'd0);
    check("reset_flags", {27'd0, out_ce, out_last, in_ready, busy, done}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // T1: k=0, constant sample, unity twiddle
    start_frame(0);
    for (int n = 0; n < N; n++) send(32'h1000_0000, 32'h1000_0000, 0);
    wait_done();

    // T2: k=4 -> phase 4 is -j, phase 8 is -1; zero samples give 0x1
    start_frame(4);
    for (int n = 0; n < N; n++) begin
      if (n == 1)      send(32'h4000_0000, 32'h0000_C001, 0);
      else if (n == 2) send(32'h4000_0000, 32'hC001_0000, 0);
      else             send(32'h0000_0000, 32'h0000_0001, 0);
    end
    wait_done();

    // T3: k=2, n=1 saturates re
    start_frame(2);
    for (int n = 0; n < N; n++) begin
      if (n == 1) send(32'h8000_8000, 32'h8000_0000, 0);
      else        send(32'h0000_0000, 32'h0000_0001, 0);
    end
    wait_done();

    // T5 + T6b: k=3, sample every other cycle, stray start mid-frame
    p0 = prod_cnt;
    start_frame(3);
    for (int n = 0; n < N; n++) begin
      x  = samp(n);
      ev = model(x, m_phase);
      if (n == 5) begin
        start = 1'b1;
        bin_k = 4'd7;
      end
      send(x, ev, 1);
      start = 1'b0;
      if (n == 5) check("start_ignored_busy", {31'd0, busy}, 32'd1);
    end
    wait_done();
    check("t5_product_count", 32'(prod_cnt - p0), 32'd16);

    // T6a: reset after the 7th accept
    start_frame(1);
    for (int n = 0; n < 7; n++) begin
      x = samp(n + 3);
      send(x, model(x, m_phase), 0);
    end
    nrst = 1'b0;
    @(negedge clk);
    check("midreset_out_data", out_data, 32'd0);
    check("midreset_flags", {27'd0, out_ce, out_last, in_ready, busy, done}, 32'd0);
    nrst = 1'b1;
    sbq.delete();
    ce_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_ce === 1'b1) ce_seen++;
    end
    check("midreset_no_stale", 32'(ce_seen), 32'd0);

    // T6c: clean frame after reset
    start_frame(5);
    for (int n = 0; n < N; n++) begin
      x = samp(15 - n);
      send(x, model(x, m_phase), (n % 3 == 0) ? 2 : 0);
    end
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
